// File: rtl/mips_mem_pkg.sv
// Shared address map and STATUS layout for the data-side memory responder.
package mips_mem_pkg;

  // Memory-mapped peripheral register addresses (full 32-bit decode)
  localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0008;

  // STATUS register field positions
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 8;

  // Target selected by the current data address
  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_CYCLE,
    REG_TXDATA,
    REG_STATUS
  } region_e;

  // Map a byte address to its target; RAM occupies [0, 2^(ram_aw+2))
  function automatic region_e decode_region(input logic [31:0] addr, input int ram_aw);
    region_e r;
    r = REG_NONE;
    if ((addr >> (ram_aw + 2)) == 32'd0) r = REG_RAM;
    else if (addr == CYCLE_ADDR)         r = REG_CYCLE;
    else if (addr == TXDATA_ADDR)        r = REG_TXDATA;
    else if (addr == STATUS_ADDR)        r = REG_STATUS;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// Synchronous FIFO with combinational head output and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full + simultaneous pop frees the head slot, so the push can land
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next-state pointer and occupancy arithmetic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder for the single-cycle MIPS core: word RAM, a free-running
// cycle counter and a console transmit FIFO behind memory-mapped registers.
// Loads are combinational so they complete within the core's cycle.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  output logic [31:0] read_data_o32,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o8,
  input  logic        tx_ready_i
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  region_e           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_q [RAM_WORDS];
  logic [31:0]       cycle_q, cycle_d;
  logic              overflow_q, overflow_d;
  logic              fifo_push, fifo_pop;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        fifo_head;
  logic [31:0]       status_word;

  assign region  = decode_region(addr_i32, RAM_AW);
  assign ram_idx = addr_i32[RAM_AW+1:2];

  assign fifo_push  = mem_write_i && (region == REG_TXDATA);
  assign fifo_pop   = tx_valid_o && tx_ready_i;
  assign tx_valid_o = !fifo_empty;
  assign tx_data_o8 = fifo_head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (write_data_i32[7:0]),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Counter and sticky-overflow next state; writes/sets take priority
  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    overflow_d = overflow_q;
    if (mem_write_i && (region == REG_CYCLE)) cycle_d = 32'd0;
    if (mem_write_i && (region == REG_STATUS) && write_data_i32[STATUS_OVF_BIT])
      overflow_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  // Register state updates
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_q    <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM store port; read side is asynchronous for single-cycle loads
  always_ff @(posedge clk_i) begin
    if (mem_write_i && (region == REG_RAM)) ram_q[ram_idx] <= write_data_i32;
  end

  // STATUS word assembly
  always_comb begin
    status_word = 32'd0;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_OVF_BIT]   = overflow_q;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  // Load data mux
  always_comb begin
    read_data_o32 = 32'd0;
    case (region)
      REG_RAM:    read_data_o32 = ram_q[ram_idx];
      REG_CYCLE:  read_data_o32 = cycle_q;
      REG_STATUS: read_data_o32 = status_word;
      default:    read_data_o32 = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, CYCLE, console FIFO, STATUS,
// reset mid-transfer and unmapped addresses.
module tb_data_mem_responder;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int          total;
  int          bad;
  logic [31:0] cyc_model;

  data_mem_responder #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .mem_write_i    (mem_write),
    .addr_i32       (addr),
    .write_data_i32 (wdata),
    .read_data_o32  (rdata),
    .tx_valid_o     (tx_valid),
    .tx_data_o8     (tx_data),
    .tx_ready_i     (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance one clock edge, tracking the expected CYCLE value
  task automatic step();
    @(posedge clk);
    if (reset) cyc_model = 32'd0;
    else if (mem_write && addr == A_CYCLE) cyc_model = 32'd0;
    else cyc_model = cyc_model + 32'd1;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    addr = a;
    wdata = d;
    step();
    mem_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    total = 0;
    bad = 0;
    cyc_model = 32'd0;
    reset = 1'b1;
    mem_write = 1'b0;
    addr = 32'd0;
    wdata = 32'd0;
    tx_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    rd("reset_cycle", A_CYCLE, 32'd0);
    rd("reset_status", A_STATUS, 32'h0000_0001);
    chk("reset_txvalid", {31'd0, tx_valid}, 32'd0);

    // Counter: 5 cycles after reset
    for (int i = 0; i < 5; i++) step();
    rd("cycle_5", A_CYCLE, 32'd5);
    for (int i = 0; i < 5; i++) step();
    rd("cycle_10", A_CYCLE, cyc_model);
    wr(A_CYCLE, 32'h1234_5678);
    rd("cycle_clr", A_CYCLE, 32'd0);
    step();
    rd("cycle_clr_plus1", A_CYCLE, 32'd1);

    // Wrap from all-ones
    dut.cycle_q = 32'hFFFF_FFFF;
    cyc_model = 32'hFFFF_FFFF;
    rd("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
    step();
    rd("cycle_wrap", A_CYCLE, 32'd0);

    // RAM store/load, byte-offset bits ignored, neighbour untouched
    wr(32'h0000_0014, 32'h1234_5678);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    rd("ram_14", 32'h0000_0014, 32'h1234_5678);
    rd("txdata_read", A_TXDATA, 32'd0);

    // Two bytes held while not ready
    wr(A_TXDATA, 32'hFFFF_FF48);
    chk("push1_valid", {31'd0, tx_valid}, 32'd1);
    chk("push1_head", {24'd0, tx_data}, 32'h48);
    wr(A_TXDATA, 32'h0000_0069);
    rd("hi_status", A_STATUS, 32'h0000_0200);
    chk("hi_head", {24'd0, tx_data}, 32'h48);
    step();
    chk("hi_head_held", {24'd0, tx_data}, 32'h48);
    tx_ready = 1'b1;
    #1;
    chk("hi_deliver0", {23'd0, tx_valid, tx_data}, 32'h148);
    step();
    chk("hi_deliver1", {23'd0, tx_valid, tx_data}, 32'h169);
    step();
    chk("hi_drained_valid", {31'd0, tx_valid}, 32'd0);
    rd("hi_drained_status", A_STATUS, 32'h0000_0001);
    tx_ready = 1'b0;

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) wr(A_TXDATA, 32'h10 + 32'(i));
    rd("ovf_status", A_STATUS, 32'h0000_0806);
    wr(A_STATUS, 32'h0000_0004);
    rd("ovf_cleared", A_STATUS, 32'h0000_0802);
    // Full with simultaneous push and pop: push accepted, no overflow
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'h0000_00AA);
    rd("full_pushpop", A_STATUS, 32'h0000_0802);
    // Drain: 0x10 left in the push+pop cycle, 0x18 was dropped
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, drain_exp[i]});
      step();
    end
    chk("drain_done_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Reset with three bytes queued and sink ready
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h30 + 32'(i));
    tx_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_txvalid", {31'd0, tx_valid}, 32'd0);
    rd("rst_status", A_STATUS, 32'h0000_0001);
    rd("rst_cycle", A_CYCLE, 32'd0);
    tx_ready = 1'b0;

    // Unmapped addresses
    wr(32'h0000_0000, 32'hCAFE_F00D);
    wr(A_TXDATA, 32'h0000_0055);
    rd("unmapped_rd_1000", 32'h0000_1000, 32'd0);
    rd("unmapped_rd_c", 32'hFFFF_000C, 32'd0);
    wr(32'h0000_1000, 32'hFFFF_FFFF);
    wr(32'hFFFF_000C, 32'h0000_0000);
    wr(32'hFFFF_0010, 32'h0000_0004);
    rd("unmapped_ram0", 32'h0000_0000, 32'hCAFE_F00D);
    rd("unmapped_status", A_STATUS, 32'h0000_0100);
    chk("unmapped_head", {23'd0, tx_valid, tx_data}, 32'h155);
    rd("unmapped_cycle", A_CYCLE, cyc_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
